// File: rtl/ram_io_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ram_io_responder
// Description : Byte-wide bus responder: synchronous RAM plus an I/O window
//               holding UART TX/RX FIFOs and a sticky halt register.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_io_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int TX_DEPTH   = 8,
    parameter int RX_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        in_ram_write_flag,
    input  logic [31:0] in_ram_address,
    input  logic [7:0]  in_ram_data,
    output logic [7:0]  out_ram_data,
    output logic        out_uart_full,
    output logic        out_tx_valid,
    output logic [7:0]  out_tx_data,
    input  logic        in_tx_ready,
    input  logic        in_rx_valid,
    input  logic [7:0]  in_rx_data,
    output logic        out_halt,
    output logic        out_overflow
);

    localparam int TX_PW = $clog2(TX_DEPTH);
    localparam int TX_CW = TX_PW + 1;
    localparam int RX_PW = $clog2(RX_DEPTH);
    localparam int RX_CW = RX_PW + 1;

    localparam logic [TX_CW-1:0] TX_FULL_CNT  = TX_CW'(TX_DEPTH);
    localparam logic [TX_CW-1:0] TX_NEAR_FULL = TX_CW'(TX_DEPTH - 1);
    localparam logic [RX_CW-1:0] RX_FULL_CNT  = RX_CW'(RX_DEPTH);

    localparam logic [2:0] IO_OFF_DATA = 3'd0;
    localparam logic [2:0] IO_OFF_CTRL = 3'd4;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic                  io_sel;
    logic [2:0]            io_off;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  bus_wr;
    logic                  bus_rd;
    logic                  tx_push_req;
    logic                  halt_set;
    logic                  rx_pop_req;
    logic                  unused_addr;

    assign io_sel      = (in_ram_address[17:16] == 2'b11);
    assign io_off      = in_ram_address[2:0];
    assign ram_addr    = in_ram_address[ADDR_WIDTH-1:0];
    assign bus_wr      = rdy &  in_ram_write_flag;
    assign bus_rd      = rdy & ~in_ram_write_flag;
    assign tx_push_req = bus_wr & io_sel & (io_off == IO_OFF_DATA);
    assign halt_set    = bus_wr & io_sel & (io_off == IO_OFF_CTRL);
    assign rx_pop_req  = bus_rd & io_sel & (io_off == IO_OFF_DATA);
    assign unused_addr = ^in_ram_address[31:18];

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]       tx_mem_q [TX_DEPTH];
    logic [TX_PW-1:0] tx_head_q, tx_head_d;
    logic [TX_PW-1:0] tx_tail_q, tx_tail_d;
    logic [TX_CW-1:0] tx_count_q, tx_count_d;
    logic             tx_valid;
    logic             tx_full;
    logic             tx_pop;
    logic             tx_push;
    logic             tx_drop;

    assign tx_valid = (tx_count_q != '0);
    assign tx_full  = (tx_count_q == TX_FULL_CNT);
    assign tx_pop   = tx_valid & in_tx_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign tx_push  = tx_push_req & (~tx_full | tx_pop);
    assign tx_drop  = tx_push_req & ~tx_push;

    always_comb begin
        tx_head_d  = tx_head_q;
        tx_tail_d  = tx_tail_q;
        tx_count_d = tx_count_q;
        if (tx_pop) begin
            tx_head_d = tx_head_q + TX_PW'(1);
        end
        if (tx_push) begin
            tx_tail_d = tx_tail_q + TX_PW'(1);
        end
        case ({tx_push, tx_pop})
            2'b10:   tx_count_d = tx_count_q + TX_CW'(1);
            2'b01:   tx_count_d = tx_count_q - TX_CW'(1);
            default: tx_count_d = tx_count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [7:0]       rx_mem_q [RX_DEPTH];
    logic [RX_PW-1:0] rx_head_q, rx_head_d;
    logic [RX_PW-1:0] rx_tail_q, rx_tail_d;
    logic [RX_CW-1:0] rx_count_q, rx_count_d;
    logic             rx_nonempty;
    logic             rx_full;
    logic             rx_pop;
    logic             rx_push;
    logic             rx_drop;

    assign rx_nonempty = (rx_count_q != '0);
    assign rx_full     = (rx_count_q == RX_FULL_CNT);
    assign rx_pop      = rx_pop_req & rx_nonempty;
    assign rx_push     = in_rx_valid & (~rx_full | rx_pop);
    assign rx_drop     = in_rx_valid & ~rx_push;

    always_comb begin
        rx_head_d  = rx_head_q;
        rx_tail_d  = rx_tail_q;
        rx_count_d = rx_count_q;
        if (rx_pop) begin
            rx_head_d = rx_head_q + RX_PW'(1);
        end
        if (rx_push) begin
            rx_tail_d = rx_tail_q + RX_PW'(1);
        end
        case ({rx_push, rx_pop})
            2'b10:   rx_count_d = rx_count_q + RX_CW'(1);
            2'b01:   rx_count_d = rx_count_q - RX_CW'(1);
            default: rx_count_d = rx_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem_q[tx_tail_q] <= in_ram_data;
        end
        if (rx_push) begin
            rx_mem_q[rx_tail_q] <= in_rx_data;
        end
    end

    // ------------------------------------------------------------------
    // RAM array (no reset so it maps onto block RAM)
    // ------------------------------------------------------------------
    logic [7:0] mem [0:(1 << ADDR_WIDTH) - 1];
    logic [7:0] ram_rdata_q;

    always_ff @(posedge clk) begin
        if (rdy) begin
            if (in_ram_write_flag && !io_sel) begin
                mem[ram_addr] <= in_ram_data;
            end
            ram_rdata_q <= mem[ram_addr];
        end
    end

    // ------------------------------------------------------------------
    // Read-data path: RAM read register or I/O read register, both
    // captured on the same edge; the select flop picks the one in use.
    // ------------------------------------------------------------------
    logic       rd_sel_ram_q, rd_sel_ram_d;
    logic [7:0] io_rdata_q, io_rdata_d;
    logic       uart_full_q, uart_full_d;
    logic       halt_q, halt_d;
    logic       overflow_q, overflow_d;

    always_comb begin
        rd_sel_ram_d = rd_sel_ram_q;
        io_rdata_d   = io_rdata_q;
        if (rdy) begin
            if (in_ram_write_flag) begin
                rd_sel_ram_d = 1'b0;
                io_rdata_d   = 8'h00;
            end else if (!io_sel) begin
                rd_sel_ram_d = 1'b1;
            end else begin
                rd_sel_ram_d = 1'b0;
                case (io_off)
                    IO_OFF_DATA: io_rdata_d = rx_nonempty ? rx_mem_q[rx_head_q] : 8'h00;
                    IO_OFF_CTRL: io_rdata_d = {6'b0, rx_nonempty, tx_full};
                    default:     io_rdata_d = 8'h00;
                endcase
            end
        end
    end

    // Near-full leaves one slot for a write the controller already issued.
    assign uart_full_d = (tx_count_d >= TX_NEAR_FULL);
    assign halt_d      = halt_q | halt_set;
    assign overflow_d  = overflow_q | tx_drop | rx_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_head_q    <= '0;
            tx_tail_q    <= '0;
            tx_count_q   <= '0;
            rx_head_q    <= '0;
            rx_tail_q    <= '0;
            rx_count_q   <= '0;
            rd_sel_ram_q <= 1'b0;
            io_rdata_q   <= 8'h00;
            uart_full_q  <= 1'b0;
            halt_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            tx_head_q    <= tx_head_d;
            tx_tail_q    <= tx_tail_d;
            tx_count_q   <= tx_count_d;
            rx_head_q    <= rx_head_d;
            rx_tail_q    <= rx_tail_d;
            rx_count_q   <= rx_count_d;
            rd_sel_ram_q <= rd_sel_ram_d;
            io_rdata_q   <= io_rdata_d;
            uart_full_q  <= uart_full_d;
            halt_q       <= halt_d;
            overflow_q   <= overflow_d;
        end
    end

    assign out_ram_data  = rd_sel_ram_q ? ram_rdata_q : io_rdata_q;
    assign out_uart_full = uart_full_q;
    assign out_tx_valid  = tx_valid;
    assign out_tx_data   = tx_valid ? tx_mem_q[tx_head_q] : 8'h00;
    assign out_halt      = halt_q;
    assign out_overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_io_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ram_io_responder
// Description : Directed self-checking bench for ram_io_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_io_responder;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        in_ram_write_flag;
    logic [31:0] in_ram_address;
    logic [7:0]  in_ram_data;
    logic [7:0]  out_ram_data;
    logic        out_uart_full;
    logic        out_tx_valid;
    logic [7:0]  out_tx_data;
    logic        in_tx_ready;
    logic        in_rx_valid;
    logic [7:0]  in_rx_data;
    logic        out_halt;
    logic        out_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    ram_io_responder #(
        .ADDR_WIDTH (17),
        .TX_DEPTH   (8),
        .RX_DEPTH   (8)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .in_ram_write_flag (in_ram_write_flag),
        .in_ram_address    (in_ram_address),
        .in_ram_data       (in_ram_data),
        .out_ram_data      (out_ram_data),
        .out_uart_full     (out_uart_full),
        .out_tx_valid      (out_tx_valid),
        .out_tx_data       (out_tx_data),
        .in_tx_ready       (in_tx_ready),
        .in_rx_valid       (in_rx_valid),
        .in_rx_data        (in_rx_data),
        .out_halt          (out_halt),
        .out_overflow      (out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [31:0] addr, input logic [7:0] data);
        in_ram_write_flag = 1'b1;
        in_ram_address    = addr;
        in_ram_data       = data;
        cycle();
    endtask

    task automatic bus_rd(input logic [31:0] addr);
        in_ram_write_flag = 1'b0;
        in_ram_address    = addr;
        in_ram_data       = 8'h00;
        cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rdy = 1'b1;
        in_ram_write_flag = 1'b0; in_ram_address = 32'h0; in_ram_data = 8'h00;
        in_tx_ready = 1'b0; in_rx_valid = 1'b0; in_rx_data = 8'h00;
        repeat (3) cycle();
        rst = 1'b0;

        // Reset state
        check("rst_rdata",    out_ram_data,  8'h00);
        check("rst_full",     out_uart_full, 1'b0);
        check("rst_txvalid",  out_tx_valid,  1'b0);
        check("rst_txdata",   out_tx_data,   8'h00);
        check("rst_halt",     out_halt,      1'b0);
        check("rst_overflow", out_overflow,  1'b0);

        // RAM write / read, latency and alias of upper address bits
        bus_wr(32'h0001_1 - 32'h1_0000 + 32'h0, 8'h3C); // write to an unmapped I/O offset, ignored
        bus_wr(32'h0000_0011, 8'h3C);
        bus_rd(32'h0000_0011);
        check("ram_rd_11a", out_ram_data, 8'h3C);
        bus_wr(32'h0000_0010, 8'hA5);
        check("wr_zero", out_ram_data, 8'h00);
        bus_rd(32'h0000_0010);
        check("ram_rd_10", out_ram_data, 8'hA5);
        bus_rd(32'h0000_0011);
        check("ram_rd_11b", out_ram_data, 8'h3C);
        bus_rd(32'h0002_0010);
        check("ram_alias", out_ram_data, 8'hA5);
        bus_rd(32'h0003_0006);
        check("io_unmapped", out_ram_data, 8'h00);

        // TX fill with UART stalled
        in_tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus_wr(32'h0003_0000, 8'h41 + 8'(i));
            check($sformatf("tx_full_after_%0d", i + 1), out_uart_full, (i >= 6) ? 1'b1 : 1'b0);
        end
        check("tx_valid_fill", out_tx_valid, 1'b1);
        check("tx_no_ovf",     out_overflow, 1'b0);
        bus_wr(32'h0003_0000, 8'h49);
        check("tx_ovf", out_overflow, 1'b1);
        bus_rd(32'h0003_0004);
        check("status_txfull", out_ram_data, 8'h01);
        in_tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("tx_drain_%0d", i), out_tx_data, 8'h41 + 8'(i));
            bus_rd(32'h0);
        end
        check("tx_drained",      out_tx_valid,  1'b0);
        check("tx_full_cleared", out_uart_full, 1'b0);

        // rdy low freezes the bus side but not the FIFO edges
        in_tx_ready = 1'b0;
        bus_wr(32'h0000_0020, 8'h77);
        in_rx_valid = 1'b1; in_rx_data = 8'h55;
        bus_rd(32'h0000_0010);
        in_rx_valid = 1'b0;
        bus_wr(32'h0003_0000, 8'h61);
        bus_wr(32'h0003_0000, 8'h62);
        bus_rd(32'h0000_0010);
        rdy = 1'b0; in_tx_ready = 1'b1;
        in_rx_valid = 1'b1; in_rx_data = 8'h66;
        bus_wr(32'h0000_0020, 8'h99);
        in_rx_valid = 1'b0;
        check("rdy0_hold_a", out_ram_data, 8'hA5);
        check("rdy0_txdata", out_tx_data,  8'h62);
        bus_rd(32'h0003_0000);
        check("rdy0_hold_b",  out_ram_data, 8'hA5);
        check("rdy0_txvalid", out_tx_valid, 1'b0);
        rdy = 1'b1; in_tx_ready = 1'b0;
        bus_rd(32'h0000_0020);
        check("rdy0_ram_kept", out_ram_data, 8'h77);
        bus_rd(32'h0003_0000);
        check("rdy0_rx_first", out_ram_data, 8'h55);
        bus_rd(32'h0003_0000);
        check("rdy0_rx_push", out_ram_data, 8'h66);
        bus_rd(32'h0003_0000);
        check("rdy0_rx_empty", out_ram_data, 8'h00);

        // Reset with TX bytes queued, halt and overflow set
        for (int i = 0; i < 7; i++) begin
            bus_wr(32'h0003_0000, 8'hC0 + 8'(i));
        end
        check("pre_rst_full", out_uart_full, 1'b1);
        bus_wr(32'h0003_0004, 8'h01);
        check("halt_set", out_halt, 1'b1);
        bus_rd(32'h0000_0010);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst2_txvalid",  out_tx_valid,  1'b0);
        check("rst2_full",     out_uart_full, 1'b0);
        check("rst2_halt",     out_halt,      1'b0);
        check("rst2_overflow", out_overflow,  1'b0);
        check("rst2_rdata",    out_ram_data,  8'h00);
        check("rst2_txdata",   out_tx_data,   8'h00);

        // TX push+pop at full across a pointer wrap
        in_tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) bus_wr(32'h0003_0000, 8'h81 + 8'(i));
        in_tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("wrap_pre_%0d", i), out_tx_data, 8'h81 + 8'(i));
            bus_rd(32'h0);
        end
        in_tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) bus_wr(32'h0003_0000, 8'h90 + 8'(i));
        check("wrap_full", out_uart_full, 1'b1);
        in_tx_ready = 1'b1;
        bus_wr(32'h0003_0000, 8'h98);
        check("wrap_no_ovf",  out_overflow,  1'b0);
        check("wrap_head",    out_tx_data,   8'h91);
        check("wrap_full2",   out_uart_full, 1'b1);
        in_tx_ready = 1'b0;
        bus_rd(32'h0003_0004);
        check("wrap_status", out_ram_data, 8'h01);
        in_tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("wrap_drain_%0d", i), out_tx_data, (i < 7) ? 8'h91 + 8'(i) : 8'h98);
            bus_rd(32'h0);
        end
        check("wrap_empty", out_tx_valid, 1'b0);
        in_tx_ready = 1'b0;

        // RX basic pop, status, empty read
        in_rx_valid = 1'b1; in_rx_data = 8'h7F;
        bus_rd(32'h0);
        in_rx_valid = 1'b0;
        bus_rd(32'h0003_0004);
        check("rx_status", out_ram_data, 8'h02);
        bus_rd(32'h0003_0000);
        check("rx_pop", out_ram_data, 8'h7F);
        bus_rd(32'h0003_0000);
        check("rx_empty", out_ram_data, 8'h00);

        // RX fill, overflow, push+pop while full
        for (int i = 0; i < 9; i++) begin
            in_rx_valid = 1'b1; in_rx_data = 8'h10 + 8'(i);
            bus_rd(32'h0);
        end
        in_rx_valid = 1'b0;
        check("rx_ovf", out_overflow, 1'b1);
        in_rx_valid = 1'b1; in_rx_data = 8'h19;
        bus_rd(32'h0003_0000);
        in_rx_valid = 1'b0;
        check("rx_full_pop", out_ram_data, 8'h10);
        for (int i = 0; i < 8; i++) begin
            bus_rd(32'h0003_0000);
            check($sformatf("rx_seq_%0d", i), out_ram_data, (i < 7) ? 8'h11 + 8'(i) : 8'h19);
        end
        bus_rd(32'h0003_0000);
        check("rx_empty_end", out_ram_data, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
